// File: rtl/fifo_pkg.sv
// Shared helpers for the DPRAM-backed stream FIFO.
// Pointer arithmetic is done on a wide container and masked to the pointer width.
package fifo_pkg;

  localparam int PTR_CALC_W = 32;
  localparam logic [PTR_CALC_W-1:0] PTR_CALC_ONE = 1;

  // Occupancy from wrap-bit pointers: (wr - rd) modulo 2**ptr_w.
  function automatic logic [PTR_CALC_W-1:0] ptr_diff(
    input logic [PTR_CALC_W-1:0] wr,
    input logic [PTR_CALC_W-1:0] rd,
    input int unsigned           ptr_w
  );
    logic [PTR_CALC_W-1:0] mask;
    mask = (ptr_w >= PTR_CALC_W) ? '1 : ((PTR_CALC_ONE << ptr_w) - PTR_CALC_ONE);
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/dpram_stream_fifo_dpram.sv
// Dual-port block RAM: port A and port B each with enable/write/reset; doutb in no_change mode.
// Latency: 1 cycle from enb to doutb; doutb holds whenever enb=0 or port B writes.
// Backpressure: none; the caller gates the enables.
module dpram_stream_fifo_dpram #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     ena,
  input  logic                     wea,
  input  logic [ADDRESS_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dina,
  input  logic                     clkb,
  input  logic                     rstb,
  input  logic                     enb,
  input  logic                     web,
  input  logic [ADDRESS_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0]    dinb,
  output logic [DATA_WIDTH-1:0]    doutb
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both write ports land in one process so the array has a single driver;
  // this RAM is only used with clka and clkb tied to the same clock.
  always_ff @(posedge clka) begin
    if (enb && web) begin
      mem[addrb] <= dinb;
    end
    if (ena && wea && !rsta) begin
      mem[addra] <= dina;
    end
  end

  always_ff @(posedge clkb) begin
    if (rstb) begin
      doutb <= '0;
    end else if (enb && !web) begin
      doutb <= mem[addrb];
    end
  end

endmodule

// File: rtl/dpram_stream_fifo.sv
// First-word-fall-through valid/ready FIFO on one DPRAM; doutb is the output register.
// Latency: 2 cycles write-to-m_valid when empty; 1 word/clk sustained.
// Backpressure: s_ready drops when the RAM holds DEPTH words; m_data holds while m_ready=0.
module dpram_stream_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [ADDRESS_WIDTH:0]  level
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH:0] level_t;

  localparam level_t DEPTH_L = level_t'(DEPTH);
  localparam level_t PTR_ONE = level_t'(1);

  level_t wr_ptr;
  level_t rd_ptr;
  level_t ram_cnt;
  logic   wr_go;
  logic   rd_go;

  assign ram_cnt = level_t'(ptr_diff(PTR_CALC_W'(wr_ptr), PTR_CALC_W'(rd_ptr),
                                     unsigned'(ADDRESS_WIDTH + 1)));

  // s_ready depends on stored state only, so a same-cycle read never frees a slot early.
  assign s_ready = (ram_cnt != DEPTH_L);
  assign wr_go   = s_valid && s_ready && !rst && !flush;
  assign rd_go   = (ram_cnt != '0) && (!m_valid || m_ready) && !rst && !flush;
  assign level   = ram_cnt + level_t'(m_valid);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (rd_go) begin
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  dpram_stream_fifo_dpram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clka  (clk),
    .rsta  (rst),
    .ena   (wr_go),
    .wea   (wr_go),
    .addra (wr_ptr[ADDRESS_WIDTH-1:0]),
    .dina  (s_data),
    .clkb  (clk),
    .rstb  (rst),
    .enb   (rd_go),
    .web   (1'b0),
    .addrb (rd_ptr[ADDRESS_WIDTH-1:0]),
    .dinb  ({DATA_WIDTH{1'b0}}),
    .doutb (m_data)
  );

endmodule

// File: tb/tb_dpram_stream_fifo.sv
// Directed and random stimulus against a queue model of words accepted but not yet delivered.
module tb_dpram_stream_fifo;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW:0]   level;

  int total = 0;
  int bad   = 0;
  int delivered;
  int accepted;
  logic [DW-1:0] q [$];

  always #5 clk = ~clk;

  dpram_stream_fifo #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; resolve this cycle's handshakes in the model, clock once,
  // then compare the occupancy invariants at the following negedge.
  task automatic tick();
    logic [DW-1:0] exp_d;
    #1;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", m_valid, 0);
        end else begin
          exp_d = q.pop_front();
          chk("data_order", m_data, exp_d);
        end
        delivered++;
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        accepted++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("level_vs_model", level, q.size());
    chk("level_le_max", (level <= DEPTH + 1), 1);
    chk("s_ready_with_room", (s_ready || q.size() >= DEPTH), 1);
    chk("m_valid_when_empty", (m_valid && q.size() == 0), 0);
  endtask

  initial begin
    int nxt;
    int prev_acc;
    int budget;

    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    delivered = 0; accepted = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_s_ready", s_ready, 1);

    // 1: single word, 2-cycle latency, level 1,1,0
    s_valid = 1'b1; s_data = 32'hA0; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("t1_level_a", level, 1);
    chk("t1_m_valid_a", m_valid, 0);
    tick();
    chk("t1_m_valid_b", m_valid, 1);
    chk("t1_m_data", m_data, 32'hA0);
    chk("t1_level_b", level, 1);
    tick();
    chk("t1_level_c", level, 0);

    // 2: fill under backpressure: 4 in RAM plus the held output word
    m_ready = 1'b0; accepted = 0;
    for (int i = 1; i <= 6; i++) begin
      s_valid = 1'b1; s_data = DW'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("t2_accepted", accepted, 5);
    chk("t2_s_ready", s_ready, 0);
    chk("t2_level", level, 5);
    chk("t2_m_valid", m_valid, 1);
    chk("t2_m_data", m_data, 1);
    tick();
    tick();
    chk("t2_m_data_held", m_data, 1);

    // 3: drain from full while writing, across the address wrap
    nxt = 6; m_ready = 1'b1; delivered = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = DW'(nxt); prev_acc = accepted;
      tick();
      if (accepted != prev_acc) nxt++;
    end
    chk("t3_throughput", delivered, 20);
    s_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("t3_drained", q.size(), 0);

    // 4: random traffic, 1000 words
    delivered = 0; budget = 0;
    while (delivered < 1000 && budget < 20000) begin
      s_valid = 1'($urandom_range(1, 0));
      s_data  = $urandom;
      m_ready = 1'($urandom_range(1, 0));
      tick();
      budget++;
    end
    chk("t4_words_done", (delivered >= 1000), 1);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("t4_drained", q.size(), 0);

    // 5: flush with 3 words queued and a write offered
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + DW'(i);
      tick();
    end
    chk("t5_queued", level, 3);
    flush = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_level", level, 0);
    chk("t5_s_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 32'h77; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("t5_post_m_valid", m_valid, 1);
    chk("t5_post_m_data", m_data, 32'h77);
    tick();

    // 6: reset mid-stream with a word on the output
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h200 + DW'(i);
      tick();
    end
    chk("t6_pre_m_valid", m_valid, 1);
    rst = 1'b1; s_valid = 1'b1; s_data = 32'hBAD; m_ready = 1'b1;
    tick();
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_level", level, 0);
    s_valid = 1'b1; s_data = 32'h5A5A; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("t6_post_m_valid", m_valid, 1);
    chk("t6_post_m_data", m_data, 32'h5A5A);
    tick();
    chk("t6_post_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
